// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl
//   Compares two WIDTH-bit unsigned words by time-sharing one external 1-bit
//   equality comparator. One bit pair per cycle is presented MSB first on
//   cmp_x/cmp_y, and the comparator's answer cmp_z is folded into a
//   word-level eq/gt/lt result.
//
//   Optional build macro: SERIAL_COMP_EARLY_EXIT_EN
//     defined   -> the first mismatching bit ends the compare at that edge
//     undefined -> every compare runs the full WIDTH cycles
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : request; only accepted while busy=0
//   a, b   : operands, captured on the accepting edge
//   busy   : high while bit pairs are being compared
//   done   : one-cycle pulse, eq/gt/lt valid from this cycle
//   eq/gt/lt : word-level result, held until the next done
//   cmp_x  : bit of A to the shared comparator
//   cmp_y  : bit of B to the shared comparator
//   cmp_z  : comparator answer (1 when cmp_x == cmp_y), same cycle
module serial_comp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             cmp_x,
    output logic             cmp_y,
    input  logic             cmp_z
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             mm;
    logic             rel;

    logic             load;
    logic             step;
    logic             finish;
    logic             mm_nxt;
    logic             rel_nxt;
    logic             first_diff;

    // First mismatch only; later comparator answers are ignored.
    assign first_diff = ~cmp_z & ~mm;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        cmp_x     = 1'b0;
        cmp_y     = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        mm_nxt    = mm;
        rel_nxt   = rel;

        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end
            end

            CMP: begin
                busy  = 1'b1;
                cmp_x = sa[WIDTH-1];
                cmp_y = sb[WIDTH-1];
                step  = 1'b1;
                if (first_diff) begin
                    mm_nxt  = 1'b1;
                    rel_nxt = sa[WIDTH-1];
                end
`ifdef SERIAL_COMP_EARLY_EXIT_EN
                if ((cnt == '0) || first_diff) begin
`else
                if (cnt == '0) begin
`endif
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            mm  <= 1'b0;
            rel <= 1'b0;
            eq  <= 1'b0;
            gt  <= 1'b0;
            lt  <= 1'b0;
        end else begin
            if (load) begin
                sa  <= a;
                sb  <= b;
                cnt <= CW'(WIDTH - 1);
                mm  <= 1'b0;
                rel <= 1'b0;
            end else if (step) begin
                sa  <= sa << 1;
                sb  <= sb << 1;
                cnt <= cnt - 1'b1;
                mm  <= mm_nxt;
                rel <= rel_nxt;
            end
            // Result uses this cycle's mismatch decision so an early exit
            // on the deciding bit still reports it.
            if (finish) begin
                eq <= ~mm_nxt;
                gt <= mm_nxt & rel_nxt;
                lt <= mm_nxt & ~rel_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
module tb_serial_comp_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;
    logic         cmp_x;
    logic         cmp_y;
    logic         cmp_z;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [2:0]   prev_res;

    always #5 clk = ~clk;

    // The shared 1-bit equality comparator.
    assign cmp_z = (cmp_x == cmp_y);

    serial_comp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt),
        .cmp_x (cmp_x),
        .cmp_y (cmp_y),
        .cmp_z (cmp_z)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the accepting edge until done is seen.
    function automatic int exp_lat(input logic [W-1:0] va, input logic [W-1:0] vb);
        int first;
        first = 0;
        for (int n = 1; n <= W; n++)
            if (first == 0 && va[W-n] != vb[W-n]) first = n;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        if (first != 0) return first;
`endif
        return W;
    endfunction

    function automatic logic [2:0] exp_res(input logic [W-1:0] va, input logic [W-1:0] vb);
        return {va == vb, va > vb, va < vb};
    endfunction

    // Called in the cycle right after the accepting edge.
    task automatic run_body(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input int perturb_at, input logic p_start,
                            input logic [W-1:0] pa, input logic [W-1:0] pb);
        int           j;
        int           busy_cnt;
        int           lat;
        logic [W-1:0] sx;
        logic [W-1:0] sy;
        logic [W-1:0] mask;
        lat = exp_lat(va, vb);
        check("held_result", {29'd0, eq, gt, lt}, {29'd0, prev_res});
        sx = '0;
        sy = '0;
        busy_cnt = 0;
        j = 0;
        while (!done && j < 4 * W) begin
            if (busy) begin
                if (busy_cnt < W) begin
                    sx[W-1-busy_cnt] = cmp_x;
                    sy[W-1-busy_cnt] = cmp_y;
                end
                busy_cnt++;
            end
            if (j == perturb_at) begin
                start = p_start;
                a = pa;
                b = pb;
            end else if (j == perturb_at + 1) begin
                start = 1'b0;
            end
            tick();
            j++;
        end
        start = 1'b0;
        mask = {W{1'b1}} << (W - lat);
        check("done_latency", j, lat);
        check("busy_cycles", busy_cnt, lat);
        check("cmp_x_seq", {24'd0, sx}, {24'd0, va & mask});
        check("cmp_y_seq", {24'd0, sy}, {24'd0, vb & mask});
        check("result", {29'd0, eq, gt, lt}, {29'd0, exp_res(va, vb)});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        prev_res = exp_res(va, vb);
    endtask

    task automatic run_cmp(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input int perturb_at, input logic p_start,
                           input logic [W-1:0] pa, input logic [W-1:0] pb);
        start = 1'b1;
        a = va;
        b = vb;
        tick();
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        run_body(va, vb, perturb_at, p_start, pa, pb);
    endtask

    task automatic back_to_back(input logic [W-1:0] va, input logic [W-1:0] vb);
        start = 1'b1;
        a = va;
        b = vb;
        tick();
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        run_body(va, vb, -1, 1'b0, '0, '0);
    endtask

    task automatic idle_after();
        tick();
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_cmp_xy", {30'd0, cmp_x, cmp_y}, 32'd0);
        check("idle_result", {29'd0, eq, gt, lt}, {29'd0, prev_res});
    endtask

    initial begin
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           mode;
        int           pat;
        logic         pst;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_res = 3'b000;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {29'd0, eq, gt, lt}, 32'd0);
        check("rst_cmp_xy", {30'd0, cmp_x, cmp_y}, 32'd0);
        rst = 1'b0;
        tick();

        run_cmp(8'hA5, 8'hA5, -1, 1'b0, '0, '0);
        idle_after();
        run_cmp(8'h80, 8'h7F, -1, 1'b0, '0, '0);
        idle_after();
        // Operand A changes while the compare is running.
        run_cmp(8'h3C, 8'h3D, 3, 1'b0, 8'hFF, 8'h3D);
        idle_after();
        // A second request while busy must be ignored.
        run_cmp(8'h10, 8'h20, 2, 1'b1, 8'h01, 8'h00);
        idle_after();

        run_cmp(8'h5A, 8'h5A, -1, 1'b0, '0, '0);
        back_to_back(8'hFF, 8'h00);
        idle_after();

        // Reset in the middle of a compare.
        start = 1'b1;
        a = 8'hC3;
        b = 8'hC2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_res = 3'b000;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", {29'd0, eq, gt, lt}, 32'd0);
        check("midrst_cmp_xy", {30'd0, cmp_x, cmp_y}, 32'd0);
        repeat (W + 2) begin
            tick();
            check("no_done_after_rst", {30'd0, done, busy}, 32'd0);
        end
        run_cmp(8'h0F, 8'hF0, -1, 1'b0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            va = W'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0) vb = va;
            else if (mode == 1) vb = va ^ (W'(1) << $urandom_range(0, W - 1));
            else vb = W'($urandom);
            pat = $urandom_range(0, exp_lat(va, vb) - 1);
            pst = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                back_to_back(va, vb);
            end else begin
                idle_after();
                run_cmp(va, vb, pat, pst, W'($urandom), W'($urandom));
            end
        end
        idle_after();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
